// File: rtl/out_tag_arbiter.sv
// out_tag_arbiter: round-robin arbiter sharing one 10-bit tag channel among ncount matchers via a 2-entry buffer.
// Define OUT_TAG_ARB_SRCID_EN to store the granted source index per slot and expose it on tag_src.
module out_tag_arbiter #(
  parameter int ncount = 8,
  localparam int iw = (ncount > 1) ? $clog2(ncount) : 1
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic [ncount-1:0][9:0] dataout,
  input  logic [ncount-1:0]      data_valid,
  output logic [ncount-1:0]      data_ack,
  output logic [9:0]             tag_data,
  output logic                   tag_valid,
  input  logic                   tag_ready
`ifdef OUT_TAG_ARB_SRCID_EN
  ,
  output logic [iw-1:0]          tag_src
`endif
);
  logic [iw-1:0] rr_q, rr_d, g;
  logic [1:0] count_q, count_d;
  logic [9:0] head_q, head_d, tail_q, tail_d;
  logic found, space, push, pop, load_head, load_tail, shift;
  int j;
  always_comb begin
    g = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < ncount; k++) begin
      j = int'(rr_q) + k;
      j = (j >= ncount) ? j - ncount : j;
      if (!found && data_valid[j]) begin
        found = 1'b1;
        g = iw'(j);
      end
    end
  end
  assign pop = tag_valid && tag_ready;
  assign space = (count_q < 2'd2) || pop;
  assign push = found && space && !sclr;
  assign data_ack = push ? (ncount'(1) << g) : '0;
  // slot 0 is always the oldest tag; slot 1 only fills behind it
  assign load_head = push && (count_q == 2'd0 || (pop && count_q == 2'd1));
  assign load_tail = push && ((count_q == 2'd1 && !pop) || (count_q == 2'd2 && pop));
  assign shift = pop && count_q == 2'd2;
  always_comb begin
    rr_d = push ? ((g == iw'(ncount - 1)) ? '0 : g + 1'b1) : rr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    head_d = load_head ? dataout[g] : shift ? tail_q : head_q;
    tail_d = load_tail ? dataout[g] : tail_q;
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      rr_q <= '0;
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      rr_q <= rr_d;
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign tag_valid = count_q != 2'd0;
  assign tag_data = head_q;
`ifdef OUT_TAG_ARB_SRCID_EN
  logic [iw-1:0] hsrc_q, hsrc_d, tsrc_q, tsrc_d;
  always_comb begin
    hsrc_d = load_head ? g : shift ? tsrc_q : hsrc_q;
    tsrc_d = load_tail ? g : tsrc_q;
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      hsrc_q <= '0;
      tsrc_q <= '0;
    end else begin
      hsrc_q <= hsrc_d;
      tsrc_q <= tsrc_d;
    end
  end
  assign tag_src = hsrc_q;
`endif
endmodule

// File: tb/tb_out_tag_arbiter.sv
// tb_out_tag_arbiter: scoreboard bench for out_tag_arbiter (ncount=8 main instance, ncount=5 wrap instance).
module tb_out_tag_arbiter;
  logic clk, sclr, tag_ready, tag_valid, tag5_valid;
  logic [7:0][9:0] dout;
  logic [7:0] dv, ack;
  logic [9:0] tag_data, tag5_data;
  logic [4:0][9:0] dout5;
  logic [4:0] dv5, ack5;
  logic [2:0] tag_src, tag5_src;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  int n_cmp = 0, n_err = 0, occ = 0;

  out_tag_arbiter #(.ncount(8)) dut (
    .clock(clk), .sclr(sclr), .dataout(dout), .data_valid(dv), .data_ack(ack),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready)
`ifdef OUT_TAG_ARB_SRCID_EN
    , .tag_src(tag_src)
`endif
  );
  out_tag_arbiter #(.ncount(5)) dut5 (
    .clock(clk), .sclr(sclr), .dataout(dout5), .data_valid(dv5), .data_ack(ack5),
    .tag_data(tag5_data), .tag_valid(tag5_valid), .tag_ready(1'b1)
`ifdef OUT_TAG_ARB_SRCID_EN
    , .tag_src(tag5_src)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int exp);
    @(negedge clk);
    chk("ack", {24'b0, ack}, (exp < 0) ? 32'd0 : (32'd1 << exp));
    if (exp >= 0 && !sclr) exp_q.push_back({3'(exp), dout[exp]});
    @(posedge clk);
    #1;
    if (exp >= 0) dout[exp] = dout[exp] + 10'd8;
  endtask

  always @(negedge clk)
    if (!sclr && tag_valid && tag_ready) begin
      if (exp_q.size() == 0) chk("unexpected_tag", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("tag_data", {22'b0, tag_data}, {22'b0, mon_e[9:0]});
`ifdef OUT_TAG_ARB_SRCID_EN
        chk("tag_src", {29'b0, tag_src}, {29'b0, mon_e[12:10]});
`endif
      end
    end

  always @(posedge clk) begin
    automatic int psh = |ack;
    automatic int pp = (tag_valid && tag_ready) ? 1 : 0;
    if (sclr) occ <= 0;
    else begin
      if (psh != 0) chk("push_at_full", (psh != 0 && pp == 0 && occ == 2) ? 32'd1 : 32'd0, 32'd0);
      occ <= occ + psh - pp;
    end
  end

  initial begin
    sclr = 1; tag_ready = 1; dv = 8'hff; dv5 = '0;
    for (int i = 0; i < 8; i++) dout[i] = 10'(i);
    for (int i = 0; i < 5; i++) dout5[i] = 10'h200 + 10'(i);
    step(-1);
    step(-1);
    chk("rst_valid", {31'b0, tag_valid}, 32'd0);
    chk("rst_data", {22'b0, tag_data}, 32'd0);
`ifdef OUT_TAG_ARB_SRCID_EN
    chk("rst_src", {29'b0, tag_src}, 32'd0);
`endif
    sclr = 0;
    for (int i = 0; i < 8; i++) step(i);
    step(0);
    step(1);
    dv = 0;
    step(-1);
    step(-1);
    dv = 8'h10;
    step(4);
    dv = 8'h48;
    step(6);
    step(3);
    step(6);
    dv = 0;
    step(-1);
    step(-1);
    tag_ready = 0;
    dout[1] = 10'h101; dout[2] = 10'h202; dout[5] = 10'h305;
    dv = 8'h26;
    step(1);
    step(2);
    step(-1);
    step(-1);
    chk("stall_valid", {31'b0, tag_valid}, 32'd1);
    chk("stall_data", {22'b0, tag_data}, 32'h101);
    tag_ready = 1;
    step(5);
    step(1);
    dv = 0;
    step(-1);
    step(-1);
    step(-1);
    tag_ready = 0;
    dv = 8'h48;
    step(3);
    step(6);
    step(-1);
    sclr = 1;
    step(-1);
    exp_q.delete();
    chk("midrst_valid", {31'b0, tag_valid}, 32'd0);
    sclr = 0;
    tag_ready = 1;
    step(3);
    dv = 0;
    step(-1);
    step(-1);
    tag_ready = 0;
    dout[2] = 10'h155;
    dv = 8'h04;
    step(2);
    dv = 0;
    repeat (4) begin
      step(-1);
      chk("hold_valid", {31'b0, tag_valid}, 32'd1);
      chk("hold_data", {22'b0, tag_data}, 32'h155);
`ifdef OUT_TAG_ARB_SRCID_EN
      chk("hold_src", {29'b0, tag_src}, 32'd2);
`endif
    end
    tag_ready = 1;
    step(-1);
    step(-1);
    dv5 = 5'h10;
    @(negedge clk);
    chk("n5_ack4", {27'b0, ack5}, 32'h10);
    @(posedge clk);
    #1;
    dv5 = 5'h09;
    @(negedge clk);
    chk("n5_wrap_ack0", {27'b0, ack5}, 32'h01);
    chk("n5_tag", {22'b0, tag5_data}, 32'h204);
    chk("n5_valid", {31'b0, tag5_valid}, 32'd1);
    @(posedge clk);
    #1;
    dv5 = 5'h0a;
    @(negedge clk);
    chk("n5_ack1", {27'b0, ack5}, 32'h02);
    @(posedge clk);
    #1;
    dv5 = 0;
    step(-1);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/out_tag_arbiter.md
# out_tag_arbiter

Round-robin scheduler that shares the single 10-bit tag output channel among `ncount` matchers. It replaces fixed-priority daisy-chain collection with a fair arbiter feeding a 2-entry output buffer. It sits between the matcher array (`dataout`/`data_valid`/`data_ack`) and the downstream tag consumer (`tag_data`/`tag_valid`/`tag_ready`). It sustains one tag per cycle and never lets one matcher starve the others.

## Interface
- `ncount`, 8, number of matcher sources; legal range 1..64, need not be a power of two.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `sclr`  in  1  reset; synchronous, active-high.
- `dataout[ncount-1:0]`  in  10 each  tag offered by matcher i.
- `data_valid[ncount-1:0]`  in  1 each  matcher i offers `dataout[i]`; the matcher holds the tag stable until acked.
- `data_ack[ncount-1:0]`  out  1 each  combinational grant; the tag is consumed at this rising edge.
- `tag_data`  out  10  head-of-buffer tag.
- `tag_valid`  out  1  buffer non-empty.
- `tag_ready`  in  1  consumer accepts `tag_data` this cycle when `tag_valid` is high.
- `tag_src`  out  $clog2(ncount) (min 1)  source index of the head tag; present only with `OUT_TAG_ARB_SRCID_EN`.

## Operation
- State:
  - `rr_ptr`: highest-priority index, 0..ncount-1.
  - 2-entry buffer: two 10-bit slots, plus source-ID slots when the macro is enabled.
  - `count`: 0..2.
- Space condition: `space = (count < 2) || (tag_valid && tag_ready)`.
- Arbitration (combinational):
  - Scan `rr_ptr`, `rr_ptr+1`, … modulo ncount.
  - The winner `g` is the first i with `data_valid[i]`.
  - `data_ack[g] = space`. All other acks are 0. At most one ack is high per cycle.
- On a grant edge:
  - Push `dataout[g]` into the buffer.
  - `rr_ptr <= (g+1) mod ncount`. The wrap uses an explicit compare at ncount-1, not a power-of-two truncation.
- With no grant, `rr_ptr` holds.
- A pop occurs when `tag_valid && tag_ready`. `count` changes by push−pop. Simultaneous push and pop at count 2 is legal and leaves count at 2.
- The buffer is in-order: the head is always the oldest granted tag.
- `tag_valid` with `tag_ready` low: head data, and `tag_src` when enabled, hold stable.
- `data_valid` low on all sources: no ack, no push, pointer holds.
- `ncount=1`: `rr_ptr` is constant 0 and the block degenerates to a 2-deep FIFO.
- Illegal state: push at count 2 without a pop cannot happen because the ack is gated by `space`. The bench asserts this.

## Timing
- Reset (`sclr` high at an edge):
  - `count=0`, `rr_ptr=0`.
  - `tag_valid=0`, `tag_data=0`, `tag_src=0`.
  - All `data_ack=0` while `sclr` is high; acks are gated by `!sclr`.
- Reset mid-operation discards buffered tags. Matchers still holding `data_valid` are re-arbitrated from index 0 on the first cycle after `sclr` drops.
- Latency: ack at edge N makes the tag visible on `tag_data` with `tag_valid=1` in cycle N+1.
- No combinational path from `data_valid` to `tag_valid`.
- `data_ack` depends combinationally on `data_valid`, `rr_ptr`, `count`, `tag_ready` and `sclr`.
- Throughput: 1 tag/cycle with `tag_ready` held high.
- Fairness: a continuously valid source is granted within ncount grants.

## Configuration
- Macro `OUT_TAG_ARB_SRCID_EN`.
- Defined: each buffer slot also stores the granted index `g`. `tag_src` reports the source of the head tag and follows `tag_data` exactly.
- Undefined: `tag_src` port and storage are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then all 8 sources valid with `tag_ready=1`, tags 0x000..0x007 → acks in order 0,1,2,…,7,0,…; `tag_data` 0x000..0x007 on consecutive cycles starting 1 cycle after the first ack.
- Only sources 3 and 6 valid, with `rr_ptr` at 5 → ack 6 first, then 3, then 6; pointer becomes 7, then 4, then 7.
- `tag_ready=0`, three sources valid → exactly 2 acks, then all acks 0. Raise `tag_ready` → pop and push in the same cycle, count stays 2, tags emerge in grant order.
- `ncount=5`, source 4 granted → `rr_ptr` wraps to 0, never 5; next grant goes to source 0 if valid.
- Assert `sclr` with count=2 and sources valid → next cycle `tag_valid=0`, all acks 0. After release, first ack goes to the lowest valid index.
- With `OUT_TAG_ARB_SRCID_EN`, source 2 sends 0x155 → `tag_data=0x155`, `tag_src=2` on the same cycle; with `tag_ready` low, both hold for 4 cycles.
